// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one 32-bit memory port between fetch and data sides
//
// Purpose:
//   Sequences fetch (I-side) and data (D-side) accesses onto a single memory
//   port through an IDLE -> BUSY -> RESP handshake. When both sides request
//   together, the side that was not served last wins. D-side stores get byte
//   enables and replicated store data derived from the access size.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a BUSY cycle counter aborts an access after TIMEOUT cycles
//   without m_ack. The granted side still gets its ack with rdata unchanged,
//   and err pulses in the same cycle. When undefined, BUSY waits forever and
//   err is tied low.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_req/i_addr      fetch request and byte address
//   i_rdata/i_ack     fetched word, 1-cycle done pulse
//   i_stall           i_req & ~i_ack
//   d_req/d_we        data request, 1 = store
//   d_swhb            access size: 01 word, 10 half, 11 byte (00 treated as word)
//   d_addr/d_wdata    data byte address, right-aligned store data
//   d_rdata/d_ack     raw loaded word, 1-cycle done pulse
//   d_stall           d_req & ~d_ack
//   m_req/m_we        memory request (registered), memory write
//   m_addr            word-aligned memory address
//   m_wdata/m_be      replicated store data, byte enables
//   m_rdata/m_ack     memory read data, memory done (same cycle)
//   err               timeout pulse (0 without ARB_TIMEOUT_EN)

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_swhb,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_stall,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_be,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;

  // grant_d / last_d: 1 means D-side, 0 means I-side.
  logic grant_d;
  logic last_d;

  logic          req_any;
  logic          pick_d;
  logic [3:0]    d_be;
  logic [DW-1:0] d_wdata_rep;

  // Fetch accesses are always word-aligned; the low address bits carry no
  // information for this block.
  logic unused_i_addr_bits;
  assign unused_i_addr_bits = ^i_addr[1:0];

  // Arbitration: a lone requester wins; on a tie the side that was not
  // served last wins, so after reset (last = I) the first tie goes to D.
  always_comb begin
    req_any = i_req | d_req;
    pick_d  = d_req & (~i_req | ~last_d);
  end

  // Byte enables. A misaligned halfword only looks at addr[1]; no fault.
  always_comb begin
    d_be = 4'b1111;
    case (d_swhb)
      2'b10:   d_be = d_addr[1] ? 4'b1100 : 4'b0011;
      2'b11:   d_be = 4'b0001 << d_addr[1:0];
      default: d_be = 4'b1111;
    endcase
  end

  // Store data is replicated across all lanes so memory can pick any lane
  // with m_be alone.
  always_comb begin
    d_wdata_rep = d_wdata;
    case (d_swhb)
      2'b10:   d_wdata_rep = {2{d_wdata[15:0]}};
      2'b11:   d_wdata_rep = {4{d_wdata[7:0]}};
      default: d_wdata_rep = d_wdata;
    endcase
  end

  // Stalls track the live request so the hazard logic releases the stage in
  // the same cycle the ack pulse is seen.
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      grant_d <= 1'b0;
      last_d  <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= 4'b0000;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt <= '0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            // Latch every request field so the requester may drop or change
            // its inputs while the memory access is in flight.
            grant_d <= pick_d;
            m_req   <= 1'b1;
            state   <= S_BUSY;
            if (pick_d) begin
              m_we    <= d_we;
              m_addr  <= {d_addr[AW-1:2], 2'b00};
              m_be    <= d_be;
              m_wdata <= d_wdata_rep;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= {i_addr[AW-1:2], 2'b00};
              m_be    <= 4'b1111;
              m_wdata <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        S_BUSY: begin
          if (m_ack) begin
            if (grant_d) begin
              d_rdata <= m_rdata;
            end else begin
              i_rdata <= m_rdata;
            end
            m_req  <= 1'b0;
            last_d <= grant_d;
            i_ack  <= ~grant_d;
            d_ack  <= grant_d;
            state  <= S_RESP;
          end
`ifdef ARB_TIMEOUT_EN
          // Abort: complete the handshake toward the requester without
          // touching its rdata register, and flag the error.
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            m_req  <= 1'b0;
            last_d <= grant_d;
            i_ack  <= ~grant_d;
            d_ack  <= grant_d;
            err    <= 1'b1;
            state  <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        S_RESP: begin
          // Ack is visible for this one cycle; no grant here, which fixes
          // back-to-back throughput at one access per three cycles.
          i_ack <= 1'b0;
          d_ack <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          err   <= 1'b0;
`endif
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
